data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle data-memory responder for the MEM stage of the 5-stage MIPS pipeline. It replaces the single-cycle combinational data memory. It accepts one load or store per request from the MEM stage and splits it into two 16-bit accesses to an external asynchronous SRAM. It deasserts `ready` until the access completes; `~ready` drives the pipeline-wide `Freeze`.

## Interface
Reset `rst` is asynchronous and active-high; the clock is `clk`.

Parameters:
- `ADDR_W`, default 18: SRAM halfword address width.
- `WAIT_CYCLES`, default 1: extra wait cycles per 16-bit access (0..15).

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `rd_en` in 1: load request from the MEM stage.
- `wr_en` in 1: store request from the MEM stage.
- `addr` in 32: byte address, already offset by the MEM stage (−1024). Bits [1:0] are ignored.
- `wdata` in 32: store value (`ST_val`).
- `rdata` out 32: registered load result.
- `ready` out 1: request complete or no request; the pipeline freezes while low.
- `sram_addr` out ADDR_W: halfword address.
- `sram_dq_out` out 16: write data.
- `sram_dq_in` in 16: read data.
- `sram_dq_oe` out 1: drive `sram_dq_out` onto the bus.
- `sram_we_n` out 1: SRAM write strobe, active-low.

## Operation
- The FSM has four states: IDLE, LO, HI, DONE. A 4-bit wait counter `wcnt` runs inside LO and HI.
- **IDLE:**
  - If `rd_en|wr_en`, latch `op_wr = wr_en`, go to LO, clear `wcnt`.
  - If both are asserted, the write wins and `rdata` is left untouched.
- **LO and HI:**
  - Stay in the state until `wcnt == WAIT_CYCLES`, incrementing `wcnt` each cycle.
  - On the final cycle, LO moves to HI with `wcnt` cleared, and HI moves to DONE.
- **DONE:** unconditionally go to IDLE.
- **`ready` (combinational):** `= ~(rd_en|wr_en) | (state==DONE)`.
- **`sram_addr`:** `{addr[ADDR_W:2], half}`, with `half` = 0 in LO and 1 in HI. It is 0 in IDLE and DONE.
- **Reads:**
  - `sram_dq_in` is sampled on the final cycle of LO into `rdata[15:0]` and on the final cycle of HI into `rdata[31:16]`.
  - `rdata` holds its value until the next read overwrites it.
- **Writes:**
  - `sram_dq_oe = 1` throughout LO and HI.
  - `sram_dq_out` is `wdata[15:0]` in LO and `wdata[31:16]` in HI.
  - `sram_we_n = 0` on every LO/HI cycle except the final cycle of each half when `WAIT_CYCLES > 0`; this gives address/data hold. With `WAIT_CYCLES = 0`, `we_n = 0` for the single cycle.
  - Outside writes, `we_n = 1` and `oe = 0`.
- **Request dropped mid-transaction** (`rd_en`/`wr_en` fall in LO/HI): the transaction completes anyway, so no torn writes. `ready` goes high as soon as the request is gone.
- **Reset:** state IDLE, `wcnt` = 0, `rdata` = 0, `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_addr` = 0, `sram_dq_out` = 0. `ready` follows its formula. Reset asserted mid-access aborts immediately; a partial SRAM write is permitted.

## Timing
- Let cycle 0 be the first cycle a request is visible. The sequence is:
  - cycle 0: IDLE;
  - cycles 1..W+1: LO;
  - cycles W+2..2W+2: HI;
  - cycle 2W+3: DONE.
- `ready` is low in cycles 0..2W+2 (2W+3 freeze cycles) and high in cycle 2W+3. The pipeline advances at the end of that cycle.
- `rdata` is valid from cycle 2W+3 onward.
- Back-to-back requests: a new request visible in the cycle after DONE starts in IDLE with no bubble beyond IDLE's single cycle.
- `addr`, `wdata` and the request signals must be held stable by the initiator while `ready` is low; the frozen pipeline guarantees this.

## Structure
- Package `mem_resp_pkg` holds:
  - the state enum (IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3);
  - `HALF_LO`/`HALF_HI` constants;
  - the default `WAIT_CYCLES`.
- One sub-module, `sram_wait_counter`. It has a 4-bit `wcnt` with clear/enable inputs and outputs `last = (wcnt == WAIT_CYCLES)`.
- All SRAM-facing outputs are registered, apart from the `sram_addr` mux, which follows state.

## Test plan
- **Reset, then idle:** `rdata=0`, `we_n=1`, `oe=0`, `ready=1`.
- **Read, W=1:** `addr=0x10`, SRAM model returns 0xBEEF at halfword 8 and 0xDEAD at halfword 9. Required: `ready` low for 5 cycles, `rdata=0xDEADBEEF` in DONE.
- **Write, W=1:** `addr=0x20`, `wdata=0x12345678`. Required: SRAM holds 0x5678 at halfword 16 and 0x1234 at halfword 17, `we_n` low for 1 cycle per half, `ready` high in cycle 5.
- **Simultaneous `rd_en`+`wr_en` with W=0:** the write is performed, `rdata` is unchanged, `ready` is low for 3 cycles.
- **Back-to-back:** a read followed by a write at consecutive addresses, with no idle gap. Required: second request's LO starts exactly 2 cycles after the first request's DONE (one IDLE cycle in between); both complete correctly.
- **Reset during HI of a write:** FSM returns to IDLE and `we_n=1` within the same cycle; a subsequent read succeeds normally.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the two-halfword SRAM data-memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic        HALF_LO             = 1'b0;
  localparam logic        HALF_HI             = 1'b1;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 1;
  localparam int unsigned WCNT_W              = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-halfword wait counter; o_last marks the final cycle of an SRAM access and
// o_last_next predicts it one cycle ahead so the strobe outputs can be registered.
module sram_wait_counter
  import mem_resp_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_last,
  output logic o_last_next
);

  localparam logic [WCNT_W-1:0] LAST_VAL = WCNT_W'(WAIT_CYCLES);

  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_next;

  always_comb begin
    w_wcnt_next = r_wcnt;
    if (i_clear) begin
      w_wcnt_next = '0;
    end else if (i_en) begin
      w_wcnt_next = r_wcnt + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= w_wcnt_next;
    end
  end

  assign o_last      = (r_wcnt == LAST_VAL);
  assign o_last_next = (w_wcnt_next == LAST_VAL);

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory front end: one 32-bit load/store becomes two 16-bit
// accesses to an asynchronous SRAM, holding ready low (pipeline freeze) meanwhile.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n
);

  localparam logic HOLD_CYCLE = (WAIT_CYCLES != 0);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_op_wr;
  logic              w_op_wr_next;
  logic              w_req;
  logic              w_clear;
  logic              w_en;
  logic              w_last;
  logic              w_last_next;
  logic              w_cap_lo;
  logic              w_cap_hi;
  logic              w_xfer_next;
  logic              w_oe_next;
  logic              w_we_n_next;
  logic [15:0]       w_dq_next;
  logic [31:0]       r_rdata;
  logic              r_we_n;
  logic              r_oe;
  logic [15:0]       r_dq_out;
  logic [ADDR_W-1:0] w_sram_addr;
  logic              w_unused_addr;

  assign w_req = rd_en | wr_en;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_en       (w_en),
    .o_last     (w_last),
    .o_last_next(w_last_next)
  );

  // Once started, a transaction runs to DONE regardless of the request, so writes never tear.
  always_comb begin
    w_state_next = r_state;
    w_op_wr_next = r_op_wr;
    w_clear      = 1'b1;
    w_en         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_next = LO;
          w_op_wr_next = wr_en;
        end
      end
      LO: begin
        if (w_last) begin
          w_state_next = HI;
        end else begin
          w_clear = 1'b0;
          w_en    = 1'b1;
        end
      end
      HI: begin
        if (w_last) begin
          w_state_next = DONE;
        end else begin
          w_clear = 1'b0;
          w_en    = 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Strobes are computed for the coming cycle so the registered outputs line up with the state.
  always_comb begin
    w_xfer_next = (w_state_next == LO) || (w_state_next == HI);
    w_oe_next   = w_xfer_next & w_op_wr_next;
    w_we_n_next = ~(w_oe_next & ~(HOLD_CYCLE & w_last_next));
    w_dq_next   = '0;
    if (w_oe_next) begin
      w_dq_next = (w_state_next == HI) ? wdata[31:16] : wdata[15:0];
    end
    w_cap_lo = (r_state == LO) & w_last & ~r_op_wr;
    w_cap_hi = (r_state == HI) & w_last & ~r_op_wr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op_wr  <= 1'b0;
      r_rdata  <= '0;
      r_we_n   <= 1'b1;
      r_oe     <= 1'b0;
      r_dq_out <= '0;
    end else begin
      r_state  <= w_state_next;
      r_op_wr  <= w_op_wr_next;
      r_we_n   <= w_we_n_next;
      r_oe     <= w_oe_next;
      r_dq_out <= w_dq_next;
      if (w_cap_lo) begin
        r_rdata[15:0] <= sram_dq_in;
      end
      if (w_cap_hi) begin
        r_rdata[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    w_sram_addr = '0;
    case (r_state)
      LO:      w_sram_addr = {addr[ADDR_W:2], HALF_LO};
      HI:      w_sram_addr = {addr[ADDR_W:2], HALF_HI};
      default: w_sram_addr = '0;
    endcase
  end

  assign w_unused_addr = &{1'b0, addr[31:ADDR_W+1], addr[1:0]};

  assign ready       = ~w_req | (r_state == DONE);
  assign rdata       = r_rdata;
  assign sram_addr   = w_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_oe;
  assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: two responders (WAIT_CYCLES=1 and 0), each on its own SRAM model.
module tb_data_mem_responder;

  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // dut1: WAIT_CYCLES = 1
  logic          rd1, wr1;
  logic [31:0]   a1, wd1, rdata1;
  logic          ready1, oe1, we1;
  logic [AW-1:0] sa1;
  logic [15:0]   dqo1, dqi1;
  logic [15:0]   mem1 [0:255];

  // dut0: WAIT_CYCLES = 0
  logic          rd0, wr0;
  logic [31:0]   a0, wd0, rdata0;
  logic          ready0, oe0, we0;
  logic [AW-1:0] sa0;
  logic [15:0]   dqo0, dqi0;
  logic [15:0]   mem0 [0:255];

  data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .addr(a1), .wdata(wd1),
    .rdata(rdata1), .ready(ready1), .sram_addr(sa1), .sram_dq_out(dqo1),
    .sram_dq_in(dqi1), .sram_dq_oe(oe1), .sram_we_n(we1)
  );

  data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .addr(a0), .wdata(wd0),
    .rdata(rdata0), .ready(ready0), .sram_addr(sa0), .sram_dq_out(dqo0),
    .sram_dq_in(dqi0), .sram_dq_oe(oe0), .sram_we_n(we0)
  );

  assign dqi1 = mem1[sa1[7:0]];
  assign dqi0 = mem0[sa0[7:0]];

  // SRAM models: preload while reset is held, otherwise write when strobed.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 16'h0000;
      mem1[8]  <= 16'hBEEF;
      mem1[9]  <= 16'hDEAD;
      mem1[24] <= 16'h3333;
      mem1[25] <= 16'h4444;
    end else if (!we1 && oe1) begin
      mem1[sa1[7:0]] <= dqo1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem0[i] <= 16'h0000;
      mem0[8] <= 16'h1111;
      mem0[9] <= 16'h2222;
    end else if (!we0 && oe0) begin
      mem0[sa0[7:0]] <= dqo0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with ready low (bounded), plus we_n-low and oe-high cycles seen meanwhile.
  task automatic wait_done(input int sel, output int n, output int wl, output int ol);
    n = 0; wl = 0; ol = 0;
    while (((sel == 1) ? !ready1 : !ready0) && n < 40) begin
      if (sel == 1) begin
        if (!we1) wl++;
        if (oe1)  ol++;
      end else begin
        if (!we0) wl++;
        if (oe0)  ol++;
      end
      tick();
      n++;
    end
  endtask

  int n, wl, ol, g;

  initial begin
    rst = 1'b1;
    rd1 = 0; wr1 = 0; a1 = '0; wd1 = '0;
    rd0 = 0; wr0 = 0; a0 = '0; wd0 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset, then idle
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_we_n1", {31'b0, we1}, 32'h1);
    chk("rst_oe1", {31'b0, oe1}, 32'h0);
    chk("rst_ready1", {31'b0, ready1}, 32'h1);
    chk("rst_addr1", {14'b0, sa1}, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_ready0", {31'b0, ready0}, 32'h1);
    $display("reset/idle checked");

    // Read, W=1, addr 0x10 -> halfwords 8/9
    rd1 = 1; a1 = 32'h10; #1;
    wait_done(1, n, wl, ol);
    chk("rd_freeze_cycles", n, 5);
    chk("rd_rdata", rdata1, 32'hDEADBEEF);
    chk("rd_we_low", wl, 0);
    rd1 = 0; tick();
    $display("read W=1 addr=0x10 rdata=0x%08h freeze=%0d", rdata1, n);

    // Write, W=1, addr 0x20 -> halfwords 16/17
    wr1 = 1; a1 = 32'h20; wd1 = 32'h12345678; #1;
    wait_done(1, n, wl, ol);
    chk("wr_freeze_cycles", n, 5);
    chk("wr_ready_done", {31'b0, ready1}, 32'h1);
    chk("wr_we_low_cycles", wl, 2);
    chk("wr_oe_cycles", ol, 4);
    chk("wr_mem16", {16'b0, mem1[16]}, 32'h5678);
    chk("wr_mem17", {16'b0, mem1[17]}, 32'h1234);
    chk("wr_rdata_kept", rdata1, 32'hDEADBEEF);
    wr1 = 0; tick();
    $display("write W=1 addr=0x20 mem=%04h_%04h we_low=%0d", mem1[17], mem1[16], wl);

    // W=0 read to give dut0 a known rdata
    rd0 = 1; a0 = 32'h10; #1;
    wait_done(0, n, wl, ol);
    chk("w0_rd_freeze", n, 3);
    chk("w0_rd_rdata", rdata0, 32'h22221111);
    rd0 = 0; tick();
    $display("read W=0 addr=0x10 rdata=0x%08h freeze=%0d", rdata0, n);

    // Simultaneous rd+wr, W=0: write wins, rdata untouched
    rd0 = 1; wr0 = 1; a0 = 32'h40; wd0 = 32'hCAFEF00D; #1;
    wait_done(0, n, wl, ol);
    chk("both_freeze", n, 3);
    chk("both_we_low", wl, 2);
    chk("both_mem32", {16'b0, mem0[32]}, 32'hF00D);
    chk("both_mem33", {16'b0, mem0[33]}, 32'hCAFE);
    chk("both_rdata_kept", rdata0, 32'h22221111);
    rd0 = 0; wr0 = 0; tick();
    $display("rd+wr W=0 addr=0x40 mem=%04h_%04h rdata=0x%08h", mem0[33], mem0[32], rdata0);

    // Back-to-back: read 0x30 then write 0x34 with no gap
    rd1 = 1; a1 = 32'h30; #1;
    wait_done(1, n, wl, ol);
    chk("b2b_rd_freeze", n, 5);
    chk("b2b_rd_rdata", rdata1, 32'h44443333);
    rd1 = 0; wr1 = 1; a1 = 32'h34; wd1 = 32'hA5A55A5A; #1;
    g = 0;
    while (!oe1 && g < 10) begin
      tick();
      g++;
    end
    chk("b2b_lo_gap", g, 2);
    wait_done(1, n, wl, ol);
    chk("b2b_wr_rest", n, 4);
    chk("b2b_mem26", {16'b0, mem1[26]}, 32'h5A5A);
    chk("b2b_mem27", {16'b0, mem1[27]}, 32'hA5A5);
    wr1 = 0; tick();
    $display("back-to-back rd 0x30=0x%08h wr 0x34 mem=%04h_%04h gap=%0d", rdata1, mem1[27], mem1[26], g);

    // Reset during HI of a write
    wr1 = 1; a1 = 32'h50; wd1 = 32'h0BAD0BAD; #1;
    tick(); tick(); tick();
    chk("hi_oe_before_rst", {31'b0, oe1}, 32'h1);
    chk("hi_we_before_rst", {31'b0, we1}, 32'h0);
    rst = 1'b1; #1;
    chk("rst_mid_we_n", {31'b0, we1}, 32'h1);
    chk("rst_mid_oe", {31'b0, oe1}, 32'h0);
    chk("rst_mid_addr", {14'b0, sa1}, 32'h0);
    chk("rst_mid_rdata", rdata1, 32'h0);
    wr1 = 0; #1;
    chk("rst_mid_ready", {31'b0, ready1}, 32'h1);
    tick();
    rst = 1'b0;
    tick();
    rd1 = 1; a1 = 32'h10; #1;
    wait_done(1, n, wl, ol);
    chk("post_rst_freeze", n, 5);
    chk("post_rst_rdata", rdata1, 32'hDEADBEEF);
    rd1 = 0; tick();
    $display("reset in HI, then read addr=0x10 rdata=0x%08h", rdata1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
